// File: rtl/mips_fetch_pkg.sv
// ============================================================================
// Module      : mips_fetch_pkg
// Description : Shared types, field widths and helpers for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    localparam int IMEM_DEPTH_DEFAULT = 128;

    localparam int OPCODE_W  = 6;
    localparam int REG_W     = 5;
    localparam int FUNCT_W   = 6;
    localparam int JTARGET_W = 26;

    // J-type targets keep the upper bits of the already-incremented PC.
    function automatic logic [31:0] make_jump_target(
        input logic [31:0]          pc_plus1,
        input logic [JTARGET_W-1:0] field
    );
        return {pc_plus1[31:JTARGET_W], field};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_ifid_reg.sv
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register with load, hold and bubble controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifid_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_pc_plus1,
    input  logic [31:0] fetch_inst,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus1,
    output logic [31:0] inst
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus1;
    logic [31:0] r_inst;

    // Bubble wins over load; with neither asserted the contents hold.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_pc_plus1 <= 32'd0;
            r_inst     <= 32'd0;
        end else if (load) begin
            r_valid    <= 1'b1;
            r_pc       <= fetch_pc;
            r_pc_plus1 <= fetch_pc_plus1;
            r_inst     <= fetch_inst;
        end
    end

    assign valid    = r_valid;
    assign pc       = r_pc;
    assign pc_plus1 = r_pc_plus1;
    assign inst     = r_inst;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module      : pc_fetch_unit
// Description : PC register, next-PC select, fetch FSM and IF/ID register.
//               Optional perf counters enabled by FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 branch_taken_i,
    input  logic [31:0]          branch_target_i,
    input  logic                 jump_i,
    input  logic [JTARGET_W-1:0] jump_target_i,
    output logic [31:0]          pc_o,
    input  logic [31:0]          inst_i,
    output logic                 ifid_valid_o,
    output logic [31:0]          ifid_inst_o,
    output logic [31:0]          ifid_pc_o,
    output logic [31:0]          ifid_pc_plus1_o,
    output logic                 halted_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          fetch_cnt_o,
    output logic [31:0]          stall_cnt_o
`endif
);

    localparam logic [31:0] c_IMEM_DEPTH = 32'(IMEM_DEPTH);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_pc_plus1;
    logic [31:0]  w_redirect_tgt;
    logic         w_redirect;
    logic         w_load;
    logic         w_bubble;

    assign w_pc_plus1     = r_pc + 32'd1;
    assign w_redirect     = jump_i | branch_taken_i;
    assign w_redirect_tgt = jump_i ? make_jump_target(w_pc_plus1, jump_target_i)
                                   : branch_target_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_bubble     = 1'b1;
                w_state_next = S_RUN;
                if (w_redirect) begin
                    w_pc_next = w_redirect_tgt;
                end
            end
            S_RUN: begin
                if (w_redirect) begin
                    w_pc_next = w_redirect_tgt;
                    w_bubble  = 1'b1;
                end else if (r_pc >= c_IMEM_DEPTH) begin
                    w_bubble     = 1'b1;
                    w_state_next = S_HALT;
                end else if (stall_i) begin
                    w_bubble = flush_i;
                end else begin
                    w_pc_next = w_pc_plus1;
                    w_bubble  = flush_i;
                    w_load    = ~flush_i;
                end
            end
            S_HALT: begin
                w_bubble = 1'b1;
                // Only an in-range redirect restarts fetch.
                if (w_redirect && (w_redirect_tgt < c_IMEM_DEPTH)) begin
                    w_pc_next    = w_redirect_tgt;
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_bubble     = 1'b1;
                w_state_next = S_BOOT;
            end
        endcase
    end

    ifid_reg u_ifid_reg (
        .clk            (clk),
        .reset          (reset),
        .load           (w_load),
        .bubble         (w_bubble),
        .fetch_pc       (r_pc),
        .fetch_pc_plus1 (w_pc_plus1),
        .fetch_inst     (inst_i),
        .valid          (ifid_valid_o),
        .pc             (ifid_pc_o),
        .pc_plus1       (ifid_pc_plus1_o),
        .inst           (ifid_inst_o)
    );

    assign pc_o     = r_pc;
    assign halted_o = (r_state == S_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (w_load) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (stall_i && (r_state == S_RUN)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign stall_cnt_o = r_stall_cnt;
`else
    // Counters absent in this build; fetch behaviour is unchanged.
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Directed scoreboard bench for pc_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ipc;
        logic        halted;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        flush_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [25:0] jump_target_i;
    logic [31:0] pc_o;
    logic [31:0] inst_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_inst_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc_plus1_o;
    logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    pc_fetch_unit #(
        .RESET_PC   (32'd0),
        .IMEM_DEPTH (128)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .pc_o            (pc_o),
        .inst_i          (inst_i),
        .ifid_valid_o    (ifid_valid_o),
        .ifid_inst_o     (ifid_inst_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_pc_plus1_o (ifid_pc_plus1_o),
        .halted_o        (halted_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o     (fetch_cnt_o),
        .stall_cnt_o     (stall_cnt_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Combinational instruction memory model.
    always_comb begin
        inst_i = 32'hFFFF_FFFF;
        if (pc_o < 32'd128) inst_i = mem_word(pc_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue the expected post-edge state, advance one edge, then score it.
    task automatic step(input logic [31:0] pc, input logic valid,
                        input logic [31:0] ipc, input logic halted);
        exp_t e;
        e.pc = pc; e.valid = valid; e.ipc = ipc; e.halted = halted;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("pc_o", pc_o, e.pc);
        check("ifid_valid_o", {31'd0, ifid_valid_o}, {31'd0, e.valid});
        check("halted_o", {31'd0, halted_o}, {31'd0, e.halted});
        if (e.valid) begin
            check("ifid_pc_o", ifid_pc_o, e.ipc);
            check("ifid_pc_plus1_o", ifid_pc_plus1_o, e.ipc + 32'd1);
            check("ifid_inst_o", ifid_inst_o, mem_word(e.ipc));
        end
    endtask

    task automatic check_ifid_zero();
        check("rst_ifid_pc", ifid_pc_o, 32'd0);
        check("rst_ifid_pc_plus1", ifid_pc_plus1_o, 32'd0);
        check("rst_ifid_inst", ifid_inst_o, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_fetch_cnt", fetch_cnt_o, 32'd0);
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        branch_taken_i = 1'b0; branch_target_i = 32'd0;
        jump_i = 1'b0; jump_target_i = 26'd0;

        // Reset and boot, then free run
        step(32'd0, 1'b0, 32'd0, 1'b0);
        check_ifid_zero();
        reset = 1'b0;
        step(32'd0, 1'b0, 32'd0, 1'b0);
        for (int i = 1; i <= 4; i++) step(32'(i), 1'b1, 32'(i - 1), 1'b0);

        // Stall two cycles at pc 4
        stall_i = 1'b1;
        step(32'd4, 1'b1, 32'd3, 1'b0);
        step(32'd4, 1'b1, 32'd3, 1'b0);
        stall_i = 1'b0;
        for (int i = 5; i <= 7; i++) step(32'(i), 1'b1, 32'(i - 1), 1'b0);

        // Branch at pc 7 to 20
        branch_taken_i = 1'b1; branch_target_i = 32'd20;
        step(32'd20, 1'b0, 32'd0, 1'b0);
        branch_taken_i = 1'b0;
        step(32'd21, 1'b1, 32'd20, 1'b0);

        // Jump beats branch and stall
        jump_i = 1'b1; jump_target_i = 26'd3;
        branch_taken_i = 1'b1; branch_target_i = 32'd50; stall_i = 1'b1;
        step(32'd3, 1'b0, 32'd0, 1'b0);
        jump_i = 1'b0; branch_taken_i = 1'b0; stall_i = 1'b0;
        step(32'd4, 1'b1, 32'd3, 1'b0);

        // Flush alone advances; flush with stall holds PC
        flush_i = 1'b1;
        step(32'd5, 1'b0, 32'd0, 1'b0);
        stall_i = 1'b1;
        step(32'd5, 1'b0, 32'd0, 1'b0);
        flush_i = 1'b0; stall_i = 1'b0;
        step(32'd6, 1'b1, 32'd5, 1'b0);

        // Run off the end of memory
        jump_i = 1'b1; jump_target_i = 26'd125;
        step(32'd125, 1'b0, 32'd0, 1'b0);
        jump_i = 1'b0;
        for (int i = 126; i <= 128; i++) step(32'(i), 1'b1, 32'(i - 1), 1'b0);
        step(32'd128, 1'b0, 32'd0, 1'b1);
        step(32'd128, 1'b0, 32'd0, 1'b1);
        branch_taken_i = 1'b1; branch_target_i = 32'd200;
        step(32'd128, 1'b0, 32'd0, 1'b1);
        branch_target_i = 32'd10;
        step(32'd10, 1'b0, 32'd0, 1'b0);
        branch_taken_i = 1'b0;
        step(32'd11, 1'b1, 32'd10, 1'b0);

        // Jump keeps upper PC bits; out-of-range target halts after one edge
        branch_taken_i = 1'b1; branch_target_i = 32'h0400_0005;
        step(32'h0400_0005, 1'b0, 32'd0, 1'b0);
        branch_taken_i = 1'b0; jump_i = 1'b1; jump_target_i = 26'd7;
        step(32'h0400_0007, 1'b0, 32'd0, 1'b0);
        jump_i = 1'b0;
        step(32'h0400_0007, 1'b0, 32'd0, 1'b1);

        // pc+1 wraps to zero, so the jump takes upper bits 0
        branch_taken_i = 1'b1; branch_target_i = 32'd40;
        step(32'd40, 1'b0, 32'd0, 1'b0);
        branch_target_i = 32'hFFFF_FFFF;
        step(32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
        branch_taken_i = 1'b0; jump_i = 1'b1; jump_target_i = 26'd0;
        step(32'd0, 1'b0, 32'd0, 1'b0);
        jump_i = 1'b0;
        step(32'd1, 1'b1, 32'd0, 1'b0);
        step(32'd2, 1'b1, 32'd1, 1'b0);

        // Reset mid-run with stall asserted
        stall_i = 1'b1; reset = 1'b1;
        step(32'd0, 1'b0, 32'd0, 1'b0);
        check_ifid_zero();
        reset = 1'b0; stall_i = 1'b0;
        step(32'd0, 1'b0, 32'd0, 1'b0);
        step(32'd1, 1'b1, 32'd0, 1'b0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
